// File: rtl/fb_burst_slave.sv
// Avalon-MM burst slave holding one frame-buffer region in on-chip RAM.
// FBS_BYTEENABLE_EN adds avs_byteenable and per-lane write masking.
module fb_burst_slave #(
  parameter int ADDR_W       = 16,
  parameter int MAX_BURST    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] avs_address,
  input  logic [4:0]  avs_burstcount,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
`ifdef FBS_BYTEENABLE_EN
  input  logic [3:0]  avs_byteenable,
`endif
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        err,
  input  logic        err_clear
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(READ_LATENCY + MAX_BURST + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_DATA  = 2'd1;
  localparam logic [1:0] S_RD_BURST = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        wr_left;
  logic [4:0]        iss_left;
  logic [CNT_W-1:0]  rd_cnt;

  logic [ADDR_W-1:0] cmd_addr;
  logic [4:0]        eff_len;
  logic              bc_bad;
  logic              st_idle;
  logic              st_wr;
  logic              st_rd;
  logic              rd_acc;
  logic              wr_first;
  logic              wr_beat;
  logic              mem_we;
  logic              rd_issue;
  logic [ADDR_W-1:0] mem_addr;
  logic              err_set;

  logic [31:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             dat_pipe [READ_LATENCY];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{avs_address[31:ADDR_W+2],
                              avs_address[1:0]};

  assign cmd_addr = avs_address[ADDR_W+1:2];

  assign st_idle = (state == S_IDLE);
  assign st_wr   = (state == S_WR_DATA);
  assign st_rd   = (state == S_RD_BURST);

  assign avs_waitrequest = st_rd;

  always_comb begin
    bc_bad  = 1'b0;
    eff_len = avs_burstcount;
    if (avs_burstcount == 5'd0) begin
      eff_len = 5'd1;
      bc_bad  = 1'b1;
    end else if (avs_burstcount > 5'(MAX_BURST)) begin
      eff_len = 5'(MAX_BURST);
      bc_bad  = 1'b1;
    end
  end

  // read wins over a simultaneous write in IDLE
  assign rd_acc   = st_idle & avs_read;
  assign wr_first = st_idle & avs_write & ~avs_read;
  assign wr_beat  = st_wr & avs_write;
  assign mem_we   = (wr_first | wr_beat) & ~reset;
  assign rd_issue = rd_acc | (st_rd & (iss_left != 5'd0));
  assign mem_addr = st_idle ? cmd_addr : cur_addr;

  always_comb begin
    err_set = 1'b0;
    unique case (1'b1)
      st_idle: err_set = ((avs_read | avs_write) & bc_bad)
                       | (avs_read & avs_write);
      st_wr:   err_set = avs_read;
      default: err_set = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      wr_left  <= '0;
      iss_left <= '0;
      rd_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (avs_read) begin
            state    <= S_RD_BURST;
            cur_addr <= cmd_addr + ADDR_W'(1);
            iss_left <= eff_len - 5'd1;
            rd_cnt   <= CNT_W'(READ_LATENCY - 2 + int'(eff_len));
          end else if (avs_write && eff_len > 5'd1) begin
            state    <= S_WR_DATA;
            cur_addr <= cmd_addr + ADDR_W'(1);
            wr_left  <= eff_len - 5'd1;
          end
        end
        S_WR_DATA: begin
          if (avs_write) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            wr_left  <= wr_left - 5'd1;
            if (wr_left == 5'd1)
              state <= S_IDLE;
          end
        end
        S_RD_BURST: begin
          if (iss_left != 5'd0) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            iss_left <= iss_left - 5'd1;
          end
          // hold off new commands until the last beat leaves
          if (rd_cnt == '0)
            state <= S_IDLE;
          else
            rd_cnt <= rd_cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef FBS_BYTEENABLE_EN
      for (int i = 0; i < 4; i++)
        if (avs_byteenable[i])
          mem[mem_addr][8*i +: 8] <= avs_writedata[8*i +: 8];
`else
      mem[mem_addr] <= avs_writedata;
`endif
    end
  end

  // stage 0 is the registered RAM output
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      if (rd_issue)
        dat_pipe[0] <= mem[mem_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1])
          dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign avs_readdatavalid = vld_pipe[READ_LATENCY-1];
  assign avs_readdata      = dat_pipe[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (err_set)
      err <= 1'b1;
    else if (err_clear)
      err <= 1'b0;
  end

endmodule

// File: tb/tb_fb_burst_slave.sv
// Scoreboard bench for fb_burst_slave with a word-array memory model.
// Builds with or without FBS_BYTEENABLE_EN.
module tb_fb_burst_slave;

  localparam int AW = 4;
  localparam int MB = 8;
  localparam int RL = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] avs_address = '0;
  logic [4:0]  avs_burstcount = 5'd1;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        err;
  logic        err_clear = 1'b0;
`ifdef FBS_BYTEENABLE_EN
  logic [3:0]  be = 4'hF;
`endif

  fb_burst_slave #(
    .ADDR_W(AW),
    .MAX_BURST(MB),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs_address(avs_address),
    .avs_burstcount(avs_burstcount),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
`ifdef FBS_BYTEENABLE_EN
    .avs_byteenable(be),
`endif
    .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .err(err),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl [DEPTH];
  logic [31:0] wdata_q[$];
  logic        exp_err = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // monitor: every valid beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h expected no beat (cycle %0d)",
                 avs_readdata, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", avs_readdata, mon_e.d);
        chk("rd_cycle", cyc, mon_e.c);
      end
    end
  end

  function automatic int eff(input int bc);
    if (bc == 0) return 1;
    if (bc > MB) return MB;
    return bc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (avs_waitrequest && b < 60) begin
      tick();
      b++;
    end
    if (avs_waitrequest) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: got waitrequest=1 expected 0 within 60 cycles");
    end
  endtask

  task automatic chk_err();
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic clear_err();
    wait_idle();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_err = 1'b0;
    chk_err();
  endtask

  task automatic do_read(input int addr_b, input int bc,
                         input bit with_wr, input bit profile);
    int n;
    int t;
    logic [AW-1:0] w;
    logic [AW-1:0] idx;
    exp_t e;
    wait_idle();
    n = eff(bc);
    t = cyc;
    w = addr_b[AW+1:2];
    avs_address = addr_b;
    avs_burstcount = bc[4:0];
    avs_read = 1'b1;
    avs_write = with_wr;
    avs_writedata = 32'hDEAD_BEEF;
    if (bc == 0 || bc > MB || with_wr) exp_err = 1'b1;
    for (int k = 0; k < n; k++) begin
      idx = w + AW'(k);
      e.d = mdl[idx];
      e.c = t + RL + k;
      sbq.push_back(e);
    end
    tick();
    avs_read = 1'b0;
    avs_write = 1'b0;
    if (profile) begin
      for (int c = 1; c <= RL + n; c++) begin
        chk("waitrequest", 32'(avs_waitrequest), 32'(c < RL + n));
        if (c < RL + n) tick();
      end
    end
  endtask

  task automatic do_write(input int addr_b, input int bc,
                          input int gap_after, input int gap_len,
                          input bit rd_in_wr);
    int n;
    logic [AW-1:0] w;
    logic [AW-1:0] idx;
    logic [31:0] d;
    wait_idle();
    n = eff(bc);
    w = addr_b[AW+1:2];
    if (bc == 0 || bc > MB) exp_err = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == gap_after + 1 && gap_len > 0) begin
        avs_write = 1'b0;
        avs_read = 1'b0;
        repeat (gap_len) tick();
      end
      if (wdata_q.size() > 0) d = wdata_q.pop_front();
      else d = $urandom;
      avs_address = addr_b;
      avs_burstcount = bc[4:0];
      avs_write = 1'b1;
      avs_writedata = d;
      avs_read = rd_in_wr && (k == 1);
      if (avs_read) exp_err = 1'b1;
      idx = w + AW'(k);
`ifdef FBS_BYTEENABLE_EN
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
`else
      mdl[idx] = d;
`endif
      tick();
    end
    avs_write = 1'b0;
    avs_read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rcount;
    int op;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    chk("rst_valid", 32'(avs_readdatavalid), 32'd0);
    chk("rst_rdata", avs_readdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // fill word i with i
    for (int i = 0; i < DEPTH; i++) wdata_q.push_back(32'(i));
    do_write(0, 8, -1, 0, 1'b0);
    do_write(32, 8, -1, 0, 1'b0);
    chk_err();

    wdata_q.push_back(32'h0000_0ABC);
    do_write(32'h10, 1, -1, 0, 1'b0);
    do_read(32'h10, 1, 1'b0, 1'b1);
    chk_err();

    for (int i = 1; i <= 8; i++) wdata_q.push_back(32'(i));
    do_write(32'h100, 8, 2, 2, 1'b0);
    do_read(32'h100, 8, 1'b0, 1'b1);
    chk_err();

    for (int i = 0; i < 8; i++) wdata_q.push_back(32'(i));
    do_write(0, 8, -1, 0, 1'b0);
    do_read(32'h38, 4, 1'b0, 1'b1);

    do_read(32'h20, 0, 1'b0, 1'b1);
    chk_err();
    clear_err();
    do_read(32'h24, 12, 1'b0, 1'b1);
    chk_err();
    clear_err();

    do_read(32'h8, 3, 1'b1, 1'b1);
    chk_err();
    clear_err();
    do_write(32'h14, 4, -1, 0, 1'b1);
    chk_err();
    clear_err();
    do_write(32'h18, 0, -1, 0, 1'b0);
    chk_err();
    clear_err();

    wdata_q.push_back(32'h1234_5678);
    do_write(32'h14, 1, -1, 0, 1'b0);
`ifdef FBS_BYTEENABLE_EN
    be = 4'b0011;
`endif
    wdata_q.push_back(32'hFFFF_FFFF);
    do_write(32'h14, 1, -1, 0, 1'b0);
`ifdef FBS_BYTEENABLE_EN
    chk("be_model", mdl[5], 32'h1234_FFFF);
    be = 4'b0000;
    do_write(32'h14, 2, -1, 0, 1'b0);
    be = 4'hF;
`else
    chk("be_model", mdl[5], 32'hFFFF_FFFF);
`endif
    do_read(32'h14, 2, 1'b0, 1'b1);

    // reset in the cycle that shows the 3rd beat of an 8-beat read
    do_read(32'h0, 8, 1'b0, 1'b0);
    rcount = 0;
    for (int c = 0; c < 20 && rcount < 3; c++) begin
      if (avs_readdatavalid) rcount++;
      if (rcount < 3) tick();
    end
    chk("rst_mid_beats", 32'(rcount), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbq.delete();
    exp_err = 1'b0;
    chk("rst_mid_waitrequest", 32'(avs_waitrequest), 32'd0);
    chk("rst_mid_valid", 32'(avs_readdatavalid), 32'd0);
    do_read(32'h28, 3, 1'b0, 1'b1);
    chk_err();

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
`ifdef FBS_BYTEENABLE_EN
      be = 4'($urandom);
`endif
      if (op < 4)
        do_write(int'($urandom), $urandom_range(1, 8),
                 $urandom_range(0, 6), $urandom_range(0, 2), 1'b0);
      else if (op == 4)
        do_write(int'($urandom), $urandom_range(0, 15),
                 -1, 0, $urandom_range(0, 1) == 1);
      else if (op < 8)
        do_read(int'($urandom), $urandom_range(1, 8), 1'b0, 1'b1);
      else if (op == 8)
        do_read(int'($urandom), $urandom_range(0, 15),
                $urandom_range(0, 1) == 1, 1'b1);
      else
        clear_err();
      chk_err();
    end

    repeat (RL + MB + 4) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
